// File: rtl/sound_pkg.sv
// sound_pkg: shared states, event classes and note tables for the sound event scheduler
package sound_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} sched_state_t;
    // Encoding order is the arbitration priority
    typedef enum logic [1:0] {EVT_NONE, EVT_DIR, EVT_GOOD, EVT_BAD} evt_t;

    localparam logic [7:0] BAD_N0  = 8'd200;
    localparam logic [7:0] BAD_N1  = 8'd160;
    localparam logic [7:0] BAD_N2  = 8'd120;
    localparam logic [7:0] GOOD_N0 = 8'd45;
    localparam logic [7:0] GOOD_N1 = 8'd30;
    localparam logic [7:0] DIR_N0  = 8'd60;

    localparam logic [1:0] BAD_LEN  = 2'd3;
    localparam logic [1:0] GOOD_LEN = 2'd2;
    localparam logic [1:0] DIR_LEN  = 2'd1;

    function automatic logic [7:0] note_code(evt_t e, logic [1:0] i);
        return e == EVT_BAD  ? (i == 2'd0 ? BAD_N0 : i == 2'd1 ? BAD_N1 : BAD_N2) :
               e == EVT_GOOD ? (i == 2'd0 ? GOOD_N0 : GOOD_N1) :
               e == EVT_DIR  ? DIR_N0 : 8'd0;
    endfunction

    function automatic logic [1:0] seq_len(evt_t e);
        return e == EVT_BAD ? BAD_LEN : e == EVT_GOOD ? GOOD_LEN : e == EVT_DIR ? DIR_LEN : 2'd0;
    endfunction

    function automatic logic [2:0] evt_mask(evt_t e);
        return {e == EVT_BAD, e == EVT_GOOD, e == EVT_DIR};
    endfunction
endpackage

// File: rtl/sound_tick_timer.sv
// sound_tick_timer: prescaler plus tick counter timing one note or gap phase
// Wraps to zero on done so back-to-back phases need no extra restart.
module sound_tick_timer #(
    parameter int TICK_DIV   = 120000,
    parameter int NOTE_TICKS = 10,
    parameter int GAP_TICKS  = 3
) (
    input  logic clk,
    input  logic nRst,
    input  logic start,
    input  logic run,
    input  logic gap,
    output logic done
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int MT = NOTE_TICKS > GAP_TICKS ? NOTE_TICKS : GAP_TICKS;
    localparam int TW = $clog2(MT + 1);

    logic [PW-1:0] pre;
    logic [TW-1:0] tick;
    logic          pre_end;

    assign pre_end = pre == PW'(TICK_DIV - 1);
    assign done    = run && pre_end && tick == (gap ? TW'(GAP_TICKS - 1) : TW'(NOTE_TICKS - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pre  <= '0;
            tick <= '0;
        end else if (start) begin
            pre  <= '0;
            tick <= '0;
        end else if (run) begin
            pre <= pre_end ? '0 : pre + 1'b1;
            if (pre_end)
                tick <= done ? '0 : tick + 1'b1;
        end
    end
endmodule

// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler: prioritised game-event note sequencer driving freq code and playSound
// Define SOUND_PENDING_EN to keep one pending request per event class, replayed at sequence end.
module sound_event_scheduler import sound_pkg::*; #(
    parameter int TICK_DIV   = 120000,
    parameter int NOTE_TICKS = 10,
    parameter int GAP_TICKS  = 3
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable_i,
    input  logic       badColl_i,
    input  logic       goodColl_i,
    input  logic       dirChg_i,
    output logic [7:0] freq_o,
    output logic       playSound_o,
    output logic       busy_o
);
    sched_state_t state, state_n;
    evt_t         cur, cur_n, req, ld, pend_evt;
    logic [1:0]   idx, idx_n;
    logic [7:0]   freq_n;
    logic         play_n, start, done, last, accept, seq_end;

    assign req     = badColl_i ? EVT_BAD : goodColl_i ? EVT_GOOD : dirChg_i ? EVT_DIR : EVT_NONE;
    assign accept  = enable_i && req != EVT_NONE && (state == IDLE || req > cur);
    assign last    = idx == seq_len(cur) - 2'd1;
    assign seq_end = done && state == PLAY && last;
    assign busy_o  = state != IDLE;

`ifdef SOUND_PENDING_EN
    logic [2:0] pend, pend_all;
    assign pend_all = pend | {badColl_i, goodColl_i, dirChg_i};
    assign pend_evt = pend_all[2] ? EVT_BAD : pend_all[1] ? EVT_GOOD : pend_all[0] ? EVT_DIR : EVT_NONE;
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            pend <= '0;
        else
            pend <= enable_i ? pend_all & ~evt_mask(ld) : 3'b0;
    end
`else
    assign pend_evt = EVT_NONE;
`endif

    sound_tick_timer #(
        .TICK_DIV(TICK_DIV),
        .NOTE_TICKS(NOTE_TICKS),
        .GAP_TICKS(GAP_TICKS)
    ) u_timer (
        .clk(clk),
        .nRst(nRst),
        .start(start),
        .run(state != IDLE),
        .gap(state == GAP),
        .done(done)
    );

    always_comb begin
        state_n = state;
        cur_n   = cur;
        idx_n   = idx;
        freq_n  = freq_o;
        play_n  = playSound_o;
        start   = 1'b0;
        ld      = accept ? req : seq_end ? pend_evt : EVT_NONE;
        if (!enable_i) begin
            state_n = IDLE;
            cur_n   = EVT_NONE;
            idx_n   = 2'd0;
            freq_n  = 8'd0;
            play_n  = 1'b0;
        end else if (ld != EVT_NONE) begin
            state_n = PLAY;
            cur_n   = ld;
            idx_n   = 2'd0;
            freq_n  = note_code(ld, 2'd0);
            play_n  = 1'b1;
            start   = 1'b1;
        end else if (seq_end) begin
            state_n = IDLE;
            cur_n   = EVT_NONE;
            idx_n   = 2'd0;
            freq_n  = 8'd0;
            play_n  = 1'b0;
        end else if (done && state == PLAY) begin
            state_n = GAP;
            idx_n   = idx + 2'd1;
            freq_n  = note_code(cur, idx + 2'd1);
            play_n  = 1'b0;
        end else if (done && state == GAP) begin
            state_n = PLAY;
            play_n  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            cur         <= EVT_NONE;
            idx         <= 2'd0;
            freq_o      <= 8'd0;
            playSound_o <= 1'b0;
        end else begin
            state       <= state_n;
            cur         <= cur_n;
            idx         <= idx_n;
            freq_o      <= freq_n;
            playSound_o <= play_n;
        end
    end
endmodule

// File: tb/tb_sound_event_scheduler.sv
// tb_sound_event_scheduler: scoreboard bench checking every output change against hand-computed events
module tb_sound_event_scheduler;
    typedef struct {
        int         cyc;
        logic       play;
        logic [7:0] freq;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic       enable_i = 1'b1;
    logic       badColl_i = 1'b0;
    logic       goodColl_i = 1'b0;
    logic       dirChg_i = 1'b0;
    logic [7:0] freq_o;
    logic       playSound_o;
    logic       busy_o;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  q[$];
    logic [9:0] prev = '0;

    sound_event_scheduler #(
        .TICK_DIV(4),
        .NOTE_TICKS(2),
        .GAP_TICKS(1)
    ) dut (
        .clk(clk),
        .nRst(nRst),
        .enable_i(enable_i),
        .badColl_i(badColl_i),
        .goodColl_i(goodColl_i),
        .dirChg_i(dirChg_i),
        .freq_o(freq_o),
        .playSound_o(playSound_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        logic [9:0] now;
        ev_t e;
        now = {playSound_o, freq_o, busy_o};
        if (now !== prev) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got play=%b freq=%0d busy=%b, none required",
                         cyc, playSound_o, freq_o, busy_o);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.play !== playSound_o || e.freq !== freq_o || e.busy !== busy_o) begin
                    n_fail++;
                    $display("FAIL seq_event got cyc=%0d play=%b freq=%0d busy=%b, required cyc=%0d play=%b freq=%0d busy=%b",
                             cyc, playSound_o, freq_o, busy_o, e.cyc, e.play, e.freq, e.busy);
                end
            end
            prev = now;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp(input int c, input logic p, input logic [7:0] f, input logic b);
        ev_t e;
        e.cyc = c; e.play = p; e.freq = f; e.busy = b;
        q.push_back(e);
    endtask

    task automatic exp_bad(input int t, input bit fin);
        exp(t + 1, 1, 200, 1); exp(t + 9, 0, 160, 1); exp(t + 13, 1, 160, 1);
        exp(t + 21, 0, 120, 1); exp(t + 25, 1, 120, 1);
        if (fin) exp(t + 33, 0, 0, 0);
    endtask

    task automatic exp_good(input int t, input bit fin);
        exp(t + 1, 1, 45, 1); exp(t + 9, 0, 30, 1); exp(t + 13, 1, 30, 1);
        if (fin) exp(t + 21, 0, 0, 0);
    endtask

    task automatic exp_dir(input int t, input bit fin);
        exp(t + 1, 1, 60, 1);
        if (fin) exp(t + 9, 0, 0, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d events outstanding, required 0", q.size());
            q.delete();
        end
        step(6);
    endtask

    initial begin
        int t;
        #1 nRst = 1'b0;
        step(3);
        n_chk++;
        if ({playSound_o, freq_o, busy_o} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state got play=%b freq=%0d busy=%b, required 0 0 0", playSound_o, freq_o, busy_o);
        end
        nRst = 1'b1;
        step(2);

        // single good collision
        t = cyc; goodColl_i = 1; exp_good(t, 1);
        step(1); goodColl_i = 0;
        drain(40);

        // simultaneous requests: bad wins
        t = cyc; badColl_i = 1; goodColl_i = 1; dirChg_i = 1;
`ifdef SOUND_PENDING_EN
        exp_bad(t, 0); exp_good(t + 32, 0); exp_dir(t + 52, 1);
`else
        exp_bad(t, 1);
`endif
        step(1); badColl_i = 0; goodColl_i = 0; dirChg_i = 0;
        drain(90);

        // dir preempted by bad at its third note cycle
        t = cyc; dirChg_i = 1; exp(t + 1, 1, 60, 1);
        step(1); dirChg_i = 0;
        step(2); badColl_i = 1; exp_bad(t + 3, 1);
        step(1); badColl_i = 0;
        drain(50);

        // lower/equal priority requests while bad is busy
        t = cyc; badColl_i = 1;
`ifdef SOUND_PENDING_EN
        exp_bad(t, 0); exp_good(t + 32, 1);
        step(1); badColl_i = 0;
        step(3); goodColl_i = 1;
        step(1); goodColl_i = 0;
        drain(70);
`else
        exp_bad(t, 1);
        step(1); badColl_i = 0;
        step(3); goodColl_i = 1;
        step(1); goodColl_i = 0;
        step(5); badColl_i = 1;
        step(1); badColl_i = 0;
        step(4); dirChg_i = 1;
        step(1); dirChg_i = 0;
        drain(50);
`endif

        // mute mid-note, pulses while muted are ignored
        t = cyc; goodColl_i = 1; exp(t + 1, 1, 45, 1);
        step(1); goodColl_i = 0;
        step(3); enable_i = 0; exp(t + 5, 0, 0, 0);
        step(1); badColl_i = 1;
        step(1); badColl_i = 0; dirChg_i = 1;
        step(1); dirChg_i = 0;
        step(3); enable_i = 1;
        drain(20);
        t = cyc; dirChg_i = 1; exp_dir(t, 1);
        step(1); dirChg_i = 0;
        drain(20);

        // async reset during a gap, then recovery
        t = cyc; goodColl_i = 1; exp(t + 1, 1, 45, 1); exp(t + 9, 0, 30, 1);
        step(1); goodColl_i = 0;
        step(9); nRst = 0; exp(t + 10, 0, 0, 0);
        #1;
        n_chk++;
        if ({playSound_o, freq_o, busy_o} !== 10'b0) begin
            n_fail++;
            $display("FAIL async_reset got play=%b freq=%0d busy=%b, required 0 0 0", playSound_o, freq_o, busy_o);
        end
        step(2); nRst = 1;
        step(1);
        t = cyc; dirChg_i = 1; exp_dir(t, 1);
        step(1); dirChg_i = 0;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
